// File: rtl/cam_capture.sv
// DVP byte-stream capture: pairs camera bytes into frame-aligned RGB565 pixel writes with coordinates and geometry checks.
// Optional CAM_CAPTURE_FRAME_COUNT_EN adds completed-frame and errored-frame counters.
module cam_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_vsync,
  input  logic          i_href,
  input  logic [7:0]    i_data,
  output logic [15:0]   o_data,
  output logic          o_wr,
  output logic          o_sof,
  output logic          o_eol,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_line_err,
`ifdef CAM_CAPTURE_FRAME_COUNT_EN
  output logic [15:0]   o_frame_count,
  output logic [15:0]   o_frame_count_err,
`endif
  output logic          o_frame_err
);

  localparam int unsigned CW = XW + 1;
  localparam int unsigned LW = YW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] W_FULL = CW'(H_ACTIVE);
  localparam logic [CW-1:0] W_SAT  = CW'(H_ACTIVE + 1);
  localparam logic [LW-1:0] L_FULL = LW'(V_ACTIVE);
  localparam logic [LW-1:0] L_SAT  = LW'(V_ACTIVE + 1);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_e;

  state_e        state_q;
  logic          vsync_q, href_q, vsync_p_q, href_p_q;
  logic [7:0]    data_q, hi_q;
  logic          phase_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] wcnt_q;
  logic [LW-1:0] lines_q, lines_d;
  logic [15:0]   pix_q;
  logic          wr_q, sof_q, eol_q, line_err_q, frame_err_q;
  logic [XW-1:0] x_o_q;
  logic [YW-1:0] y_o_q;

  logic active, vs_rise, vs_fall, line_end, frame_end, abort, byte_ok, pix;
  logic line_bad, frame_bad, line_err_d, frame_err_d, sof_d, eol_d;

  // Event decode from the registered pins; a vsync rise with href still high aborts the line.
  always_comb begin
    active      = (state_q == ACTIVE);
    vs_rise     = vsync_q & ~vsync_p_q;
    vs_fall     = ~vsync_q & vsync_p_q;
    line_end    = active & href_p_q & ~href_q;
    frame_end   = active & vs_rise;
    abort       = frame_end & href_q;
    byte_ok     = active & href_q & ~abort;
    pix         = byte_ok & phase_q;
    line_bad    = line_end & (phase_q | (wcnt_q != W_FULL));
    lines_d     = (line_end && (lines_q != L_SAT)) ? lines_q + LW'(1) : lines_q;
    frame_bad   = frame_end & (lines_d != L_FULL);
    line_err_d  = line_bad | abort;
    sof_d       = pix & (x_q == '0) & (y_q == '0);
    eol_d       = pix & (x_q == X_LAST);
    frame_err_d = sof_d ? 1'b0 : (frame_err_q | line_err_d | frame_bad);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      vsync_p_q   <= 1'b0;
      href_p_q    <= 1'b0;
      data_q      <= '0;
      hi_q        <= '0;
      phase_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      wcnt_q      <= '0;
      lines_q     <= '0;
      pix_q       <= '0;
      wr_q        <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      x_o_q       <= '0;
      y_o_q       <= '0;
    end else begin
      vsync_q     <= i_vsync;
      href_q      <= i_href;
      data_q      <= i_data;
      vsync_p_q   <= vsync_q;
      href_p_q    <= href_q;
      wr_q        <= pix;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      lines_q     <= lines_d;

      if (byte_ok) begin
        phase_q <= ~phase_q;
        if (!phase_q) hi_q <= data_q;
      end

      if (pix) begin
        pix_q <= {hi_q, data_q};
        x_o_q <= x_q;
        y_o_q <= y_q;
        if (x_q != X_LAST) x_q <= x_q + XW'(1);
        if (wcnt_q != W_SAT) wcnt_q <= wcnt_q + CW'(1);
      end

      if (line_end) begin
        x_q     <= '0;
        wcnt_q  <= '0;
        phase_q <= 1'b0;
        if (y_q != Y_LAST) y_q <= y_q + YW'(1);
      end

      // Capture only begins on a vsync falling edge, so a frame is never entered midway.
      case (state_q)
        IDLE: begin
          if (i_en) state_q <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (!i_en) begin
            state_q <= IDLE;
          end else if (vs_fall) begin
            state_q <= ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= 1'b0;
            wcnt_q  <= '0;
            lines_q <= '0;
          end
        end
        ACTIVE: begin
          if (frame_end) state_q <= i_en ? WAIT_FRAME : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data      = pix_q;
  assign o_wr        = wr_q;
  assign o_sof       = sof_q;
  assign o_eol       = eol_q;
  assign o_x         = x_o_q;
  assign o_y         = y_o_q;
  assign o_line_err  = line_err_q;
  assign o_frame_err = frame_err_q;

`ifdef CAM_CAPTURE_FRAME_COUNT_EN
  logic [15:0] fcnt_q, fcnt_err_q;

  // Completed frames wrap; errored frames saturate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fcnt_q     <= '0;
      fcnt_err_q <= '0;
    end else if (frame_end) begin
      fcnt_q <= fcnt_q + 16'd1;
      if (frame_err_d && (fcnt_err_q != 16'hFFFF)) fcnt_err_q <= fcnt_err_q + 16'd1;
    end
  end

  assign o_frame_count     = fcnt_q;
  assign o_frame_count_err = fcnt_err_q;
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture with a 4x2 frame geometry.
module tb_cam_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_href = 1'b0;
  logic [7:0]  i_data = '0;
  logic [15:0] o_data;
  logic        o_wr, o_sof, o_eol, o_line_err, o_frame_err;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
`ifdef CAM_CAPTURE_FRAME_COUNT_EN
  logic [15:0] o_frame_count, o_frame_count_err;
`endif

  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(10), .YW(9)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_vsync(i_vsync), .i_href(i_href),
    .i_data(i_data), .o_data(o_data), .o_wr(o_wr), .o_sof(o_sof), .o_eol(o_eol),
    .o_x(o_x), .o_y(o_y), .o_line_err(o_line_err),
`ifdef CAM_CAPTURE_FRAME_COUNT_EN
    .o_frame_count(o_frame_count), .o_frame_count_err(o_frame_count_err),
`endif
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic [9:0]  x;
    logic [8:0]  y;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int total = 0;
  int bad = 0;
  int n_wr = 0;
  int n_eol = 0;
  int n_lerr = 0;

  // Output monitor: every write is popped against the scoreboard.
  always @(negedge i_clk) begin
    if (o_line_err) n_lerr++;
    if (o_wr) begin
      n_wr++;
      if (o_eol) n_eol++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got data=%h x=%0d y=%0d sof=%b, required no write", o_data, o_x, o_y, o_sof);
      end else begin
        got_e = exp_q.pop_front();
        if ({o_data, o_sof, o_eol, o_x, o_y} !== {got_e.data, got_e.sof, got_e.eol, got_e.x, got_e.y}) begin
          bad++;
          $display("FAIL pixel got data=%h sof=%b eol=%b x=%0d y=%0d, required data=%h sof=%b eol=%b x=%0d y=%0d",
                   o_data, o_sof, o_eol, o_x, o_y, got_e.data, got_e.sof, got_e.eol, got_e.x, got_e.y);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(posedge i_clk);
    #1;
    i_vsync = v;
    i_href  = h;
    i_data  = d;
  endtask

  task automatic vsync_pulse();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int nbytes);
    for (int i = 1; i <= nbytes; i++) drive(1'b0, 1'b1, 8'(i));
    repeat (4) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_line(input int y, input int nbytes, input bit first);
    exp_t e;
    for (int k = 0; k < nbytes / 2; k++) begin
      e.x    = 10'((k > H - 1) ? H - 1 : k);
      e.y    = 9'(y);
      e.data = {8'(2 * k + 1), 8'(2 * k + 2)};
      e.sof  = first && (k == 0);
      e.eol  = (k >= H - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic good_frame();
    vsync_pulse();
    push_line(0, 8, 1'b1);
    send_line(8);
    push_line(1, 8, 1'b0);
    send_line(8);
  endtask

  task automatic clr_counts();
    n_wr = 0;
    n_eol = 0;
    n_lerr = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    #1;
    total++;
    if ({o_data, o_wr, o_sof, o_eol, o_x, o_y, o_line_err, o_frame_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got data=%h wr=%b x=%0d y=%0d ferr=%b, required all zero", o_data, o_wr, o_x, o_y, o_frame_err);
    end
    i_rst = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_good_frame();
    i_en = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    clr_counts();
    good_frame();
    total++;
    if (n_wr !== 8) begin bad++; $display("FAIL good_writes got=%0d required=8", n_wr); end
    total++;
    if (n_eol !== 2) begin bad++; $display("FAIL good_eol got=%0d required=2", n_eol); end
    total++;
    if (n_lerr !== 0) begin bad++; $display("FAIL good_line_err got=%0d required=0", n_lerr); end
    total++;
    if (o_frame_err !== 1'b0) begin bad++; $display("FAIL good_frame_err got=%b required=0", o_frame_err); end
  endtask

  task automatic test_late_enable();
    i_en = 1'b0;
    clr_counts();
    vsync_pulse();
    for (int i = 1; i <= 3; i++) drive(1'b0, 1'b1, 8'(i));
    i_en = 1'b1;
    for (int i = 4; i <= 8; i++) drive(1'b0, 1'b1, 8'(i));
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    send_line(8);
    total++;
    if (n_wr !== 0) begin bad++; $display("FAIL late_en_no_write got=%0d required=0", n_wr); end
    good_frame();
    total++;
    if (n_wr !== 8) begin bad++; $display("FAIL late_en_writes got=%0d required=8", n_wr); end
  endtask

  task automatic test_odd_line();
    clr_counts();
    vsync_pulse();
    push_line(0, 7, 1'b1);
    send_line(7);
    total++;
    if (n_lerr !== 1) begin bad++; $display("FAIL odd_line_err got=%0d required=1", n_lerr); end
    total++;
    if (o_frame_err !== 1'b1) begin bad++; $display("FAIL odd_frame_err_set got=%b required=1", o_frame_err); end
    push_line(1, 8, 1'b0);
    send_line(8);
    vsync_pulse();
    total++;
    if (o_frame_err !== 1'b1) begin bad++; $display("FAIL odd_frame_err_sticky got=%b required=1", o_frame_err); end
    push_line(0, 8, 1'b1);
    send_line(8);
    total++;
    if (o_frame_err !== 1'b0) begin bad++; $display("FAIL odd_frame_err_clear got=%b required=0", o_frame_err); end
    push_line(1, 8, 1'b0);
    send_line(8);
    total++;
    if (n_wr !== 15) begin bad++; $display("FAIL odd_writes got=%0d required=15", n_wr); end
    total++;
    if (n_lerr !== 1) begin bad++; $display("FAIL odd_line_err_total got=%0d required=1", n_lerr); end
  endtask

  task automatic test_abort();
    clr_counts();
    vsync_pulse();
    push_line(0, 4, 1'b1);
    for (int i = 1; i <= 5; i++) drive(1'b0, 1'b1, 8'(i));
    drive(1'b1, 1'b1, 8'h06);
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    total++;
    if (n_wr !== 2) begin bad++; $display("FAIL abort_writes got=%0d required=2", n_wr); end
    total++;
    if (n_eol !== 0) begin bad++; $display("FAIL abort_eol got=%0d required=0", n_eol); end
    total++;
    if (n_lerr !== 1) begin bad++; $display("FAIL abort_line_err got=%0d required=1", n_lerr); end
    total++;
    if (o_frame_err !== 1'b1) begin bad++; $display("FAIL abort_frame_err got=%b required=1", o_frame_err); end
    push_line(0, 8, 1'b1);
    send_line(8);
    push_line(1, 8, 1'b0);
    send_line(8);
    total++;
    if (n_wr !== 10) begin bad++; $display("FAIL abort_recapture got=%0d required=10", n_wr); end
    total++;
    if (o_frame_err !== 1'b0) begin bad++; $display("FAIL abort_err_clear got=%b required=0", o_frame_err); end
  endtask

  task automatic test_reset_mid_frame();
    clr_counts();
    vsync_pulse();
    push_line(0, 2, 1'b1);
    for (int i = 1; i <= 3; i++) drive(1'b0, 1'b1, 8'(i));
    repeat (2) @(posedge i_clk);
    #1;
    total++;
    if (o_data !== 16'h0102) begin bad++; $display("FAIL rst_pre_data got=%h required=0102", o_data); end
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_data, o_wr, o_sof, o_eol, o_x, o_y, o_line_err, o_frame_err} !== '0) begin
      bad++;
      $display("FAIL rst_async got data=%h wr=%b x=%0d y=%0d ferr=%b, required all zero", o_data, o_wr, o_x, o_y, o_frame_err);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    for (int i = 4; i <= 8; i++) drive(1'b0, 1'b1, 8'(i));
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    send_line(8);
    total++;
    if (n_wr !== 1) begin bad++; $display("FAIL rst_no_write got=%0d required=1", n_wr); end
    good_frame();
    total++;
    if (n_wr !== 9) begin bad++; $display("FAIL rst_recapture got=%0d required=9", n_wr); end
  endtask

`ifdef CAM_CAPTURE_FRAME_COUNT_EN
  task automatic test_frame_count();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    total++;
    if (o_frame_count !== 16'd0) begin bad++; $display("FAIL fcnt_reset got=%0d required=0", o_frame_count); end
    repeat (3) good_frame();
    vsync_pulse();
    push_line(0, 8, 1'b1);
    send_line(8);
    vsync_pulse();
    total++;
    if (o_frame_count !== 16'd4) begin bad++; $display("FAIL fcnt got=%0d required=4", o_frame_count); end
    total++;
    if (o_frame_count_err !== 16'd1) begin bad++; $display("FAIL fcnt_err got=%0d required=1", o_frame_count_err); end
    total++;
    if (o_frame_err !== 1'b1) begin bad++; $display("FAIL fcnt_short_err got=%b required=1", o_frame_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_late_enable();
    test_odd_line();
    test_abort();
    test_reset_mid_frame();
`ifdef CAM_CAPTURE_FRAME_COUNT_EN
    test_frame_count();
`endif
    repeat (6) drive(1'b0, 1'b0, 8'h00);
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL pending_writes got=%0d required=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Front-end capture stage between the synchronised DVP camera pins and the processing pipeline.
- Converts the camera's 8-bit byte stream (two bytes per pixel) into 16-bit RGB565 pixel writes.
- Frame-aligns capture so every frame it starts is complete.
- Produces the start-of-frame pulse consumed by sys_control (i_sof) and by downstream stages, plus per-pixel coordinates and geometry error flags.

Parameters:
- H_ACTIVE, 640, active pixels per line; sets o_x range 0..H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; sets o_y range 0..V_ACTIVE-1.
- XW, 10, width of o_x; must satisfy 2^XW >= H_ACTIVE.
- YW, 9, width of o_y; must satisfy 2^YW >= V_ACTIVE.

Ports:
- i_clk  in  1  pixel clock; all inputs synchronous to it.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  capture enable (driven from o_cfg_start completion / camera config done).
- i_vsync  in  1  camera VSYNC, high during vertical blanking.
- i_href  in  1  camera HREF, high during active line bytes.
- i_data  in  8  camera byte.
- o_data  out  16  RGB565 pixel, {first byte, second byte}.
- o_wr  out  1  one-cycle pixel-valid strobe.
- o_sof  out  1  high with o_wr on pixel (0,0) of a captured frame only.
- o_eol  out  1  high with o_wr on the last pixel of each line (o_x == H_ACTIVE-1).
- o_x  out  XW  column of the current o_data.
- o_y  out  YW  row of the current o_data.
- o_line_err  out  1  one-cycle pulse when a line ends with an odd byte count or a pixel count other than H_ACTIVE.
- o_frame_err  out  1  sticky flag for frame geometry error; cleared on the next o_sof.

Behaviour:
- Reset: all outputs 0; state IDLE; byte phase 0; counters 0.
- Input stage:
  - i_vsync, i_href and i_data are registered once (q stage).
  - All decisions use the q values and the previous vsync_q (falling-edge detect).
- State machine:
  - IDLE: no writes. Moves to WAIT_FRAME when i_en=1.
  - WAIT_FRAME: waits for a vsync_q falling edge, then moves to ACTIVE with y=0, x=0, phase=0. A frame already in progress at entry is never partially captured.
  - ACTIVE:
    - href_q=1: phase 0 latches the high byte; phase 1 forms the pixel. o_data and o_wr are registered, so o_wr is asserted on the edge after the q-stage holds the second byte (2 edges after the second byte appears on i_data).
    - Phase toggles on every href_q=1 cycle.
    - o_sof=1 iff x==0 and y==0 on that write.
    - o_eol=1 iff x==H_ACTIVE-1.
    - x increments per write, saturating at H_ACTIVE-1; writes beyond H_ACTIVE still occur with x held.
- Line end (href_q falling):
  - Pulse o_line_err if phase==1 (the odd byte is discarded, no write) or if the write count != H_ACTIVE.
  - Set o_frame_err when o_line_err pulses.
  - x<=0, phase<=0; y increments, saturating at V_ACTIVE-1.
- Frame end (vsync_q rising while ACTIVE):
  - If lines != V_ACTIVE, set o_frame_err.
  - If the rise occurs with href_q=1, the line is aborted: partial byte dropped, no o_eol, o_line_err pulsed.
  - Next state is WAIT_FRAME if i_en=1, IDLE otherwise.
- i_en deassert mid-frame: the current frame completes; the block then goes to IDLE at frame end.
- Reset mid-frame: immediate return to IDLE; the next captured frame starts only after a full vsync falling edge.
- o_x and o_y are valid only when o_wr=1 and hold their last values otherwise.
- Simultaneous events:
  - href_q falling and vsync_q rising in the same cycle: line-end processing is applied first, then frame end.
  - o_frame_err set and clear (o_sof) in the same cycle: clear wins, since it is a new frame.

Optional Feature:
- CAM_CAPTURE_FRAME_COUNT_EN defined:
  - Adds port o_frame_count out 16, counting completed frames (vsync_q rise while ACTIVE).
  - Wraps 0xFFFF->0; reset 0.
  - Adds port o_frame_count_err out 16, counting frames with o_frame_err set at frame end; saturates at 0xFFFF.
- Not defined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Parameters H_ACTIVE=4, V_ACTIVE=2. Assert i_en, send vsync pulse then 2 lines of 8 bytes 0x01..0x08:
  - exactly 8 writes.
  - First write o_data=0x0102 with o_sof=1, x=0, y=0.
  - o_eol on 0x0708 each line.
  - o_frame_err=0.
- Enable i_en mid-line of a running frame: no writes until the following vsync falling edge; first write carries o_sof=1.
- Line of 7 bytes:
  - 3 writes, last byte dropped.
  - o_line_err pulses once.
  - o_frame_err=1 until the next frame's o_sof, then 0.
- vsync rises while href high after 5 bytes:
  - 2 writes, no o_eol.
  - o_line_err pulse.
  - o_frame_err=1.
  - Block returns to WAIT_FRAME.
- Assert i_rst for 1 cycle mid-frame:
  - all outputs 0 asynchronously.
  - No write until i_en=1 and a new vsync falling edge.
- With CAM_CAPTURE_FRAME_COUNT_EN: 3 good frames plus 1 short frame (1 line):
  - o_frame_count=4.
  - o_frame_count_err=1.
